instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Parametrised successor of the single-word instruction register.
- A DEPTH-entry FIFO accepts instruction words from the memory bus ahead of use.
- An output instruction register is loaded from the FIFO head on controller request.
- Opcode/source/destination fields are split out from the instruction register for the decoder.
- Sits between the memory data bus and the control unit; flush supports branch/jump redirect.

Parameters:
- WORD_SIZE, 8, instruction word width; must equal OPCODE_W + 2*REG_W.
- OPCODE_W, 4, opcode field width (MSBs of the word).
- REG_W, 2, width of each register-select field.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all queued words and invalidate the instruction register.
- push_valid  input  1  push_data is valid this cycle.
- push_ready  output  1  queue can accept a word; equals !full.
- push_data  input  WORD_SIZE  instruction word from the memory bus.
- advance  input  1  load the next instruction from the FIFO head into the instruction register.
- ir_out  output  WORD_SIZE  current instruction register contents.
- ir_valid  output  1  ir_out holds a valid instruction.
- opcode  output  OPCODE_W  ir_out[WORD_SIZE-1 -: OPCODE_W].
- src  output  REG_W  ir_out[2*REG_W-1 -: REG_W].
- dest  output  REG_W  ir_out[REG_W-1:0].
- count  output  $clog2(DEPTH+1)  number of queued words, not counting the instruction register.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- underflow  output  1  sticky; set by advance while empty.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: read/write pointers 0, count 0, ir_out 0, ir_valid 0, underflow 0. As a result empty=1, full=0, push_ready=1, and opcode/src/dest are 0.
- Push:
  - A word is accepted when push_valid && push_ready.
  - It is written at the write pointer, and the write pointer advances modulo DEPTH.
  - push_ready is registered-state only (!full). It has no combinational path from advance.
- Advance:
  - When advance && !empty: ir_out <= head word, ir_valid <= 1, and the read pointer advances modulo DEPTH.
  - The new ir_out is visible the cycle after advance (1-cycle latency).
- Advance while empty:
  - ir_out holds its value, ir_valid <= 0, underflow <= 1.
  - underflow is cleared only by rst or flush.
  - There is no bypass: a word pushed in the same cycle is not loaded.
- Simultaneous push and advance, queue non-empty and not full: both occur and count is unchanged.
- Full queue: push_ready=0, so a push is not accepted. An advance in the same cycle still pops; push_ready becomes 1 the next cycle.
- Count: incremented on an accepted push only, decremented on a successful advance only, unchanged when both occur. count never exceeds DEPTH and never goes below 0.
- Flush:
  - Pointers <= 0, count <= 0, ir_out <= 0, ir_valid <= 0, underflow <= 0.
  - Flush has priority over push and advance in the same cycle; a pushed word is dropped.
- Priority order: rst > flush > (push, advance).
- Storage array contents are not reset; only the pointers are.
- Field outputs are combinational slices of ir_out.
- Elaboration check: flag an error if WORD_SIZE != OPCODE_W + 2*REG_W, or if DEPTH is not a power of two, or if DEPTH < 2.

Decomposition:
- Shared package spm_isa_pkg:
  - OPCODE_W and REG_W constants.
  - opcode enum type (NOP, ADD, SUB, AND, NOT, RD, WR, BR, BRZ, HALT, ...).
  - Field slice helper functions.
- One natural sub-module, sync_fifo_ptr: a DEPTH-parametrised pointer/count/full/empty tracker with wrap-around. The top level holds the storage array, the instruction register, flush, and the underflow logic.

Test Plan:
- Reset then idle: assert rst for 2 cycles → count=0, empty=1, push_ready=1, ir_out=0x00, ir_valid=0, underflow=0.
- Fill and drain:
  - Push 0x12, 0x34, 0x56, 0x78 (DEPTH=4) → full=1, push_ready=0. A fifth push of 0x9A is not accepted.
  - Advance ×4 → ir_out is 0x12, 0x34, 0x56, 0x78 in successive cycles, each one cycle after its advance. For 0x12: opcode=0x1, src=0, dest=2. ir_valid=1 throughout.
- Wrap-around: interleave 10 pushes (0x01..0x0A) with advances so the pointers wrap twice → ir_out sequence is 0x01..0x0A in order, with no loss or duplication.
- Simultaneous push+advance:
  - At count=2: count stays 2 and ir_out takes the old head.
  - At full: the advance pops, push_ready=0 that cycle, count=3 next cycle.
- Underflow: advance on an empty queue with ir_out=0x78 → ir_out stays 0x78, ir_valid=0, underflow=1. A later flush clears underflow.
- Flush mid-stream: queue holds 3 words, ir_valid=1, and in the same cycle flush + push 0xAB + advance → count=0, empty=1, ir_out=0x00, ir_valid=0. 0xAB never appears on a later advance.

Source files
------------

// File: rtl/spm_isa_pkg.sv
// Shared ISA definitions for the simple processor model: field widths,
// opcode encoding and helpers that split an instruction word into fields.
package spm_isa_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned REG_W    = 2;
  localparam int unsigned ISA_W    = OPCODE_W + 2 * REG_W;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_NOT  = 4'h4,
    OP_RD   = 4'h5,
    OP_WR   = 4'h6,
    OP_BR   = 4'h7,
    OP_BRZ  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  // Opcode occupies the MSBs of the word.
  function automatic logic [OPCODE_W-1:0] op_field(input logic [ISA_W-1:0] w);
    return w[ISA_W-1 -: OPCODE_W];
  endfunction

  function automatic logic [REG_W-1:0] src_field(input logic [ISA_W-1:0] w);
    return w[2*REG_W-1 -: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] dest_field(input logic [ISA_W-1:0] w);
    return w[REG_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer/occupancy tracker for a power-of-two FIFO.
// Ports: clk, rst (sync, active-high), clear (sync flush), push/pop (already
// qualified by caller), wr_ptr/rd_ptr (wrap modulo DEPTH), count, full, empty.
module sync_fifo_ptr #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [CW-1:0] count_nxt;

  // Simultaneous push and pop leave occupancy unchanged.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-entry FIFO fed by the memory bus, plus an
// instruction register loaded from the head on advance, with decoder fields.
// Ports: clk, rst (sync, active-high), flush; push_valid/push_ready/push_data
// from memory; advance from control; ir_out/ir_valid and opcode/src/dest to
// the decoder; count/empty/full occupancy; underflow sticky error flag.
module instr_prefetch_queue
  import spm_isa_pkg::*;
#(
  parameter  int unsigned WORD_SIZE = 8,
  parameter  int unsigned OPCODE_W  = spm_isa_pkg::OPCODE_W,
  parameter  int unsigned REG_W     = spm_isa_pkg::REG_W,
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 advance,
  output logic [WORD_SIZE-1:0] ir_out,
  output logic                 ir_valid,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [REG_W-1:0]     src,
  output logic [REG_W-1:0]     dest,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 underflow
);

  if (WORD_SIZE != OPCODE_W + 2 * REG_W) begin : g_bad_word
    $error("WORD_SIZE must equal OPCODE_W + 2*REG_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push_fire;
  logic                 pop_fire;

  // Flush outranks both push and advance.
  assign push_fire  = push_valid && !full && !flush;
  assign pop_fire   = advance && !empty && !flush;
  assign push_ready = !full;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .push   (push_fire),
    .pop    (pop_fire),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  // Instruction register and sticky underflow; no bypass from push_data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ir_out    <= '0;
      ir_valid  <= 1'b0;
      underflow <= 1'b0;
    end else if (advance) begin
      if (!empty) begin
        ir_out   <= mem[rd_ptr];
        ir_valid <= 1'b1;
      end else begin
        ir_valid  <= 1'b0;
        underflow <= 1'b1;
      end
    end
  end

  assign opcode = ir_out[WORD_SIZE-1 -: OPCODE_W];
  assign src    = ir_out[2*REG_W-1 -: REG_W];
  assign dest   = ir_out[REG_W-1:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed testbench for instr_prefetch_queue with an instruction-register
// scoreboard drained by an independent monitor.
module tb_instr_prefetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       push_valid;
  logic       push_ready;
  logic [7:0] push_data;
  logic       advance;
  logic [7:0] ir_out;
  logic       ir_valid;
  logic [3:0] opcode;
  logic [1:0] src;
  logic [1:0] dest;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       underflow;

  instr_prefetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .advance    (advance),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .opcode     (opcode),
    .src        (src),
    .dest       (dest),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  ir;
    logic        v;
    logic        uf;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  mq[$];
  logic [7:0]  m_ir;
  logic        m_v;
  logic        m_uf;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: compare the instruction register against each due expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc < cyc) begin
        chk("sb_late", cyc, e.cyc);
      end else begin
        chk("ir_out", 32'(ir_out), 32'(e.ir));
        chk("ir_valid", 32'(ir_valid), 32'(e.v));
        chk("underflow", 32'(underflow), 32'(e.uf));
      end
    end
  end

  // One clock of stimulus; expected IR state is queued for the monitor.
  task automatic step(input logic pv, input logic [7:0] pd, input logic adv, input logic fl);
    exp_t e;
    bit   acc;
    push_valid = pv;
    push_data  = pd;
    advance    = adv;
    flush      = fl;
    acc = pv && (mq.size() < 4);
    if (fl) begin
      mq.delete();
      m_ir = 8'h00;
      m_v  = 1'b0;
      m_uf = 1'b0;
    end else begin
      if (adv) begin
        if (mq.size() > 0) begin
          m_ir = mq.pop_front();
          m_v  = 1'b1;
        end else begin
          m_v  = 1'b0;
          m_uf = 1'b1;
        end
      end
      if (acc) mq.push_back(pd);
    end
    if (adv || fl) begin
      e.cyc = cyc + 1;
      e.ir  = m_ir;
      e.v   = m_v;
      e.uf  = m_uf;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    advance    = 1'b0;
    flush      = 1'b0;
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == 4));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = 8'h00; advance = 1'b0;
    m_ir = 8'h00; m_v = 1'b0; m_uf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_ir_out", 32'(ir_out), 0);
    chk("rst_ir_valid", 32'(ir_valid), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_fields", {opcode, src, dest}, 0);

    // Fill, then an overflow push that must be refused.
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h56, 1'b0, 1'b0);
    step(1'b1, 8'h78, 1'b0, 1'b0);
    chk("fill_push_ready", 32'(push_ready), 0);
    step(1'b1, 8'h9A, 1'b0, 1'b0);
    chk("overflow_count", 32'(count), 4);

    // Drain in order.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain0_ir", 32'(ir_out), 32'h12);
    chk("drain0_opcode", 32'(opcode), 1);
    chk("drain0_src", 32'(src), 0);
    chk("drain0_dest", 32'(dest), 2);
    chk("drain0_push_ready", 32'(push_ready), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain3_ir", 32'(ir_out), 32'h78);

    // Underflow holds ir_out, drops ir_valid, sets sticky flag; flush clears.
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("uf_ir", 32'(ir_out), 32'h78);
    chk("uf_flag", 32'(underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("uf_sticky", 32'(underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("uf_flush", 32'(underflow), 0);

    // Wrap-around: pointers pass DEPTH twice.
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), (i > 1), 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last_ir", 32'(ir_out), 32'h0A);

    // Simultaneous push and advance at count=2.
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h23, 1'b1, 1'b0);
    chk("simul2_count", 32'(count), 2);
    chk("simul2_ir", 32'(ir_out), 32'h21);

    // At full: advance pops, push refused, ready returns next cycle.
    step(1'b1, 8'h24, 1'b0, 1'b0);
    step(1'b1, 8'h25, 1'b0, 1'b0);
    chk("full_before", 32'(push_ready), 0);
    step(1'b1, 8'h26, 1'b1, 1'b0);
    chk("full_pop_count", 32'(count), 3);
    chk("full_pop_ir", 32'(ir_out), 32'h22);
    chk("full_pop_ready", 32'(push_ready), 1);

    // Flush mid-stream with concurrent push and advance.
    chk("pre_flush_valid", 32'(ir_valid), 1);
    step(1'b1, 8'hAB, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 0);
    chk("flush_ir", 32'(ir_out), 0);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_ir", 32'(ir_out), 32'h31);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_uf_ir", 32'(ir_out), 32'h31);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
